// File: rtl/pulse_train_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_train_pkg;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_NUM_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;
endpackage

// File: rtl/pulse_train_phase_counter.sv
// Down-counter for one high or low phase; `zero` is registered and tracks cnt == 0.
module phase_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else if (load) begin
            cnt  <= load_val;
            zero <= (load_val == '0);
        end else if (en && cnt != '0) begin
            // Saturates at zero: a phase never wraps around.
            cnt  <= cnt - CNT_W'(1);
            zero <= (cnt == CNT_W'(1));
        end
    end
endmodule

// File: rtl/pulse_train_gen.sv
// Generates `count` pulses of high_len/low_len cycles after a one-cycle start.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] count,
    output logic             signal_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] remaining
);
    state_t           state;
    logic [CNT_W-1:0] h_q, l_q;
    logic [CNT_W-1:0] h_eff, l_eff;
    logic             accept;
    logic             zero;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;

    // Zero-length phases are stretched to one cycle.
    assign h_eff  = (high_len == '0) ? CNT_W'(1) : high_len;
    assign l_eff  = (low_len == '0) ? CNT_W'(1) : low_len;
    assign accept = (state == IDLE) && start && !abort;

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: if (accept) begin
                cnt_load = 1'b1;
                cnt_val  = h_eff - CNT_W'(1);
            end
            HIGH: if (!abort && zero) begin
                cnt_load = 1'b1;
                cnt_val  = l_q - CNT_W'(1);
            end
            LOW: if (!abort && zero && remaining != '0) begin
                cnt_load = 1'b1;
                cnt_val  = h_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (state != IDLE),
        .load_val (cnt_val),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            h_q        <= '0;
            l_q        <= '0;
            signal_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    h_q <= h_eff;
                    l_q <= l_eff;
                    if (count == '0) begin
                        done <= 1'b1;
                    end else begin
                        state      <= HIGH;
                        signal_out <= 1'b1;
                        busy       <= 1'b1;
                        remaining  <= count - NUM_W'(1);
                    end
                end
                HIGH: if (abort) begin
                    state      <= IDLE;
                    signal_out <= 1'b0;
                    busy       <= 1'b0;
                    remaining  <= '0;
                end else if (zero) begin
                    state      <= LOW;
                    signal_out <= 1'b0;
                end
                LOW: if (abort) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    remaining  <= '0;
                end else if (zero) begin
                    if (remaining != '0) begin
                        state      <= HIGH;
                        signal_out <= 1'b1;
                        remaining  <= remaining - NUM_W'(1);
                    end else begin
                        // Trailing low phase finished: train complete.
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    signal_out <= 1'b0;
                    busy       <= 1'b0;
                    remaining  <= '0;
                end
            endcase
        end
    end
endmodule
